event_capture_8: RTL and testbench



---
 rtl/event_capture_8_if.sv | 31 +++
 rtl/event_capture_8.sv | 121 ++++++++++++
 tb/tb_event_capture_8.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/event_capture_8_if.sv
// Bus bundle for event_capture_8.
//   master : request side (drives I0..I7, MASK, ACK, CLR_LOST; observes status)
//   slave  : the capture/arbiter block (drives P0..P7, VALID, IDX, LOST)
//   I0..I7   async event request lines
//   MASK     per-channel arbitration mask (1 = excluded, still captured)
//   ACK      consumer accepts the current grant
//   CLR_LOST pulse that clears LOST
//   P0..P7   sticky pending flags, one per channel
//   VALID    grant valid
//   IDX      granted channel number
//   LOST     sticky "edge arrived on an already pending channel"
interface event_capture_8_if;
    logic       I0, I1, I2, I3, I4, I5, I6, I7;
    logic [7:0] MASK;
    logic       ACK;
    logic       CLR_LOST;
    logic       P0, P1, P2, P3, P4, P5, P6, P7;
    logic       VALID;
    logic [2:0] IDX;
    logic       LOST;

    modport master (
        output I0, I1, I2, I3, I4, I5, I6, I7, MASK, ACK, CLR_LOST,
        input  P0, P1, P2, P3, P4, P5, P6, P7, VALID, IDX, LOST
    );

    modport slave (
        input  I0, I1, I2, I3, I4, I5, I6, I7, MASK, ACK, CLR_LOST,
        output P0, P1, P2, P3, P4, P5, P6, P7, VALID, IDX, LOST
    );
endinterface

// File: rtl/event_capture_8.sv
// 8-channel event capture and round-robin service arbiter.
// Each async request line is synchronised (two flops), rising edges are detected against a
// third flop and latched into a sticky pending flag. One unmasked pending channel at a time is
// granted (VALID/IDX) and its flag is cleared when the consumer acknowledges.
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus_io : event_capture_8_if slave modport (requests, mask, ack, status outputs)
module event_capture_8 (
    input  logic                     clk,
    input  logic                     rst_n,
    event_capture_8_if.slave         bus_io
);

    typedef enum logic [0:0] {StIdle, StGrant} state_e;

    logic [7:0] req;
    logic [7:0] s1_q, s2_q, prev_q;
    logic [7:0] evt_edge;
    logic [7:0] pend_q, pend_d;
    logic [7:0] eligible;
    logic [7:0] clr_vec;
    logic       lost_q, lost_d;
    logic [2:0] idx_q, idx_d;
    logic [2:0] ptr_q, ptr_d;
    state_e     state_q, state_d;
    logic       pick_found;
    logic [2:0] pick_idx;
    logic [2:0] cand;

    assign req = {bus_io.I7, bus_io.I6, bus_io.I5, bus_io.I4,
                  bus_io.I3, bus_io.I2, bus_io.I1, bus_io.I0};

    assign evt_edge = s2_q & ~prev_q;
    assign eligible = pend_q & ~bus_io.MASK;

    // Round-robin search: first eligible channel starting at ptr_q, wrapping 7 -> 0.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = ptr_q;
        cand       = '0;
        for (int i = 0; i < 8; i++) begin
            cand = ptr_q + i[2:0];
            if (!pick_found && eligible[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        clr_vec = '0;
        unique case (state_q)
            StIdle: begin
                if (pick_found) begin
                    idx_d   = pick_idx;
                    state_d = StGrant;
                end
            end
            StGrant: begin
                // Grant is held regardless of mask or new edges until the consumer accepts.
                if (bus_io.ACK) begin
                    clr_vec[idx_q] = 1'b1;
                    ptr_d          = idx_q + 3'd1;
                    state_d        = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // A new edge wins over a same-cycle clear, so the flag survives an ACK collision.
    assign pend_d = (pend_q & ~clr_vec) | evt_edge;

    // A loss is an edge on a flag that stays set; it also wins over CLR_LOST.
    always_comb begin
        lost_d = lost_q;
        if (|(evt_edge & pend_q & ~clr_vec)) begin
            lost_d = 1'b1;
        end else if (bus_io.CLR_LOST) begin
            lost_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q    <= '0;
            s2_q    <= '0;
            prev_q  <= '0;
            pend_q  <= '0;
            lost_q  <= 1'b0;
            idx_q   <= '0;
            ptr_q   <= '0;
            state_q <= StIdle;
        end else begin
            s1_q    <= req;
            s2_q    <= s1_q;
            prev_q  <= s2_q;
            pend_q  <= pend_d;
            lost_q  <= lost_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
            state_q <= state_d;
        end
    end

    assign bus_io.P0    = pend_q[0];
    assign bus_io.P1    = pend_q[1];
    assign bus_io.P2    = pend_q[2];
    assign bus_io.P3    = pend_q[3];
    assign bus_io.P4    = pend_q[4];
    assign bus_io.P5    = pend_q[5];
    assign bus_io.P6    = pend_q[6];
    assign bus_io.P7    = pend_q[7];
    assign bus_io.VALID = (state_q == StGrant);
    assign bus_io.IDX   = idx_q;
    assign bus_io.LOST  = lost_q;

endmodule

// File: tb/tb_event_capture_8.sv
module tb_event_capture_8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    event_capture_8_if ecif ();

    event_capture_8 dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_io (ecif)
    );

    int unsigned checks = 0;
    int unsigned passed = 0;

    logic [7:0] cur_req, cur_mask;
    logic       cur_ack, cur_clr;

    // Reference model: sampled input history plus abstract pending set / grant / pointer.
    logic [7:0] m_samp[$];
    logic [7:0] m_p;
    logic       m_valid;
    logic [2:0] m_idx;
    int         m_ptr;
    logic       m_lost;

    typedef struct {
        logic [7:0] req;
        logic       ack;
        logic       clr;
        logic [7:0] exp_p;
        logic       exp_valid;
        logic [2:0] exp_idx;
        logic       exp_lost;
    } vec_t;

    vec_t tbl[18];

    function automatic logic [7:0] dut_p();
        return {ecif.P7, ecif.P6, ecif.P5, ecif.P4, ecif.P3, ecif.P2, ecif.P1, ecif.P0};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic apply(input logic [7:0] req, input logic [7:0] mask, input logic ack,
                         input logic clr);
        cur_req = req; cur_mask = mask; cur_ack = ack; cur_clr = clr;
        ecif.I0 = req[0]; ecif.I1 = req[1]; ecif.I2 = req[2]; ecif.I3 = req[3];
        ecif.I4 = req[4]; ecif.I5 = req[5]; ecif.I6 = req[6]; ecif.I7 = req[7];
        ecif.MASK = mask; ecif.ACK = ack; ecif.CLR_LOST = clr;
    endtask

    function automatic void model_clear();
        m_samp.delete();
        m_p = '0; m_valid = 1'b0; m_idx = '0; m_ptr = 0; m_lost = 1'b0;
    endfunction

    function automatic void model_step();
        logic [7:0] e, older, oldest, served_mask;
        logic       served, found;
        int         t;
        m_samp.push_back(cur_req);
        if (m_samp.size() > 4) void'(m_samp.pop_front());
        t = m_samp.size() - 1;
        // Edge seen at this clock: input high two samples ago, low three samples ago.
        older  = (t >= 2) ? m_samp[t-2] : 8'h00;
        oldest = (t >= 3) ? m_samp[t-3] : 8'h00;
        e = older & ~oldest;
        served = m_valid && cur_ack;
        served_mask = served ? (8'h01 << m_idx) : 8'h00;
        if ((e & m_p & ~served_mask) != 8'h00) m_lost = 1'b1;
        else if (cur_clr) m_lost = 1'b0;
        if (served) begin
            m_valid = 1'b0;
            m_ptr   = (int'(m_idx) + 1) % 8;
        end else if (!m_valid) begin
            found = 1'b0;
            for (int i = 0; i < 8; i++) begin
                int c;
                c = (m_ptr + i) % 8;
                if (!found && m_p[c] && !cur_mask[c]) begin
                    found = 1'b1; m_valid = 1'b1; m_idx = c[2:0];
                end
            end
        end
        m_p = (m_p & ~served_mask) | e;
    endfunction

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_step();
        else model_clear();
        #1;
    endtask

    task automatic cmp_model(input string tag);
        chk({tag, "_p"}, dut_p(), m_p);
        chk({tag, "_valid"}, ecif.VALID, m_valid);
        chk({tag, "_lost"}, ecif.LOST, m_lost);
        if (m_valid) chk({tag, "_idx"}, ecif.IDX, m_idx);
    endtask

    task automatic pulse(input logic [7:0] req);
        apply(req, cur_mask, 1'b0, 1'b0);
        tick();
        apply(8'h00, cur_mask, 1'b0, 1'b0);
    endtask

    task automatic wait_grant(input string tag, input logic [2:0] exp_idx);
        for (int i = 0; i < 20 && !ecif.VALID; i++) tick();
        chk({tag, "_valid"}, ecif.VALID, 1'b1);
        chk({tag, "_idx"}, ecif.IDX, exp_idx);
    endtask

    task automatic serve(input string tag, input logic [2:0] k);
        apply(8'h00, cur_mask, 1'b1, 1'b0);
        tick();
        apply(8'h00, cur_mask, 1'b0, 1'b0);
        chk({tag, "_ack_valid"}, ecif.VALID, 1'b0);
        chk({tag, "_ack_p"}, dut_p()[k], 1'b0);
    endtask

    initial begin
        logic [7:0] r, m;

        //               req    ack   clr   exp_p  v     idx   lost
        tbl[0]  = '{8'h08, 1'b0, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0};
        tbl[1]  = '{8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0};
        tbl[2]  = '{8'h00, 1'b0, 1'b0, 8'h08, 1'b0, 3'd0, 1'b0};
        tbl[3]  = '{8'h00, 1'b0, 1'b0, 8'h08, 1'b1, 3'd3, 1'b0};
        tbl[4]  = '{8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0};
        tbl[5]  = '{8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0};
        tbl[6]  = '{8'h01, 1'b0, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0};
        tbl[7]  = '{8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0};
        tbl[8]  = '{8'h00, 1'b0, 1'b0, 8'h01, 1'b0, 3'd0, 1'b0};
        tbl[9]  = '{8'h01, 1'b0, 1'b0, 8'h01, 1'b1, 3'd0, 1'b0};
        tbl[10] = '{8'h00, 1'b0, 1'b0, 8'h01, 1'b1, 3'd0, 1'b0};
        tbl[11] = '{8'h00, 1'b0, 1'b0, 8'h01, 1'b1, 3'd0, 1'b1};
        tbl[12] = '{8'h00, 1'b0, 1'b1, 8'h01, 1'b1, 3'd0, 1'b0};
        tbl[13] = '{8'h01, 1'b0, 1'b0, 8'h01, 1'b1, 3'd0, 1'b0};
        tbl[14] = '{8'h00, 1'b0, 1'b0, 8'h01, 1'b1, 3'd0, 1'b0};
        tbl[15] = '{8'h00, 1'b1, 1'b0, 8'h01, 1'b0, 3'd0, 1'b0};
        tbl[16] = '{8'h00, 1'b0, 1'b0, 8'h01, 1'b1, 3'd0, 1'b0};
        tbl[17] = '{8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0};

        // Reset held with toggling inputs.
        rst_n = 1'b0;
        model_clear();
        apply(8'h00, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            apply((i % 2 == 0) ? 8'hff : 8'h00, 8'h00, 1'b1, 1'b0);
            tick();
        end
        chk("rst_p", dut_p(), 8'h00);
        chk("rst_valid", ecif.VALID, 1'b0);
        chk("rst_idx", ecif.IDX, 3'd0);
        chk("rst_lost", ecif.LOST, 1'b0);
        apply(8'h00, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            cmp_model("idle");
        end

        // Table: single event on I3, then loss and ACK collision on I0.
        for (int i = 0; i < 18; i++) begin
            apply(tbl[i].req, 8'h00, tbl[i].ack, tbl[i].clr);
            tick();
            chk($sformatf("tbl%0d_p", i), dut_p(), tbl[i].exp_p);
            chk($sformatf("tbl%0d_valid", i), ecif.VALID, tbl[i].exp_valid);
            chk($sformatf("tbl%0d_lost", i), ecif.LOST, tbl[i].exp_lost);
            if (tbl[i].exp_valid) chk($sformatf("tbl%0d_idx", i), ecif.IDX, tbl[i].exp_idx);
        end
        apply(8'h00, 8'h00, 1'b0, 1'b0);
        tick();

        // Round-robin: 1,5,6 then (pointer at 7) 1,5.
        pulse(8'h62);
        wait_grant("rr_a", 3'd1); serve("rr_a", 3'd1);
        wait_grant("rr_b", 3'd5); serve("rr_b", 3'd5);
        wait_grant("rr_c", 3'd6); serve("rr_c", 3'd6);
        pulse(8'h22);
        wait_grant("rr_d", 3'd1); serve("rr_d", 3'd1);
        wait_grant("rr_e", 3'd5); serve("rr_e", 3'd5);

        // Mask: channel 2 captured but skipped until unmasked.
        cur_mask = 8'h04;
        pulse(8'h14);
        wait_grant("mask_a", 3'd4);
        serve("mask_a", 3'd4);
        tick(); tick();
        chk("mask_p2_held", dut_p()[2], 1'b1);
        chk("mask_no_grant", ecif.VALID, 1'b0);
        apply(8'h00, 8'h00, 1'b0, 1'b0);
        tick();
        chk("unmask_valid", ecif.VALID, 1'b1);
        chk("unmask_idx", ecif.IDX, 3'd2);
        serve("unmask", 3'd2);

        // Reset in the middle of a grant, asserted between clock edges.
        pulse(8'h40);
        wait_grant("mid", 3'd6);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        model_clear();
        chk("mid_rst_valid", ecif.VALID, 1'b0);
        chk("mid_rst_p6", dut_p()[6], 1'b0);
        tick(); tick();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            cmp_model("post_rst");
        end

        // Randomised traffic against the reference model.
        r = 8'h00;
        m = 8'h00;
        for (int i = 0; i < 1500; i++) begin
            if (i % 64 == 0) m = 8'($urandom & $urandom);
            r = r ^ 8'($urandom & $urandom & $urandom);
            apply(r, m, ($urandom_range(0, 2) == 0), ($urandom_range(0, 15) == 0));
            tick();
            cmp_model("rand");
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
